fp_div_seq: RTL
===============

Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider; computes result = A / B.
- It is the inverse operation of the FP multiplier and is the companion unit in the same arithmetic datapath.
- Its operand and rounding-mode conventions match the multiplier.
- Mantissa uses a radix-2 restoring iteration (one quotient bit per cycle) with a start/done handshake and fixed latency, so schedulers can treat it deterministically.

Parameters:
- WIDTH, 32, total operand/result width.
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state and outputs.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- A  input  WIDTH  dividend, IEEE-754 single; captured when start is accepted.
- B  input  WIDTH  divisor, IEEE-754 single; captured when start is accepted.
- rnd  input  2  rounding mode, captured with start: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
- busy  output  1  high from the cycle after start is accepted through the ROUND cycle.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WIDTH  quotient; held from the done cycle until the next done or reset.
- flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}; held with result.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, result=0, flags=0; all captured operands cleared. Reset mid-operation aborts with no done pulse.
- FSM states IDLE -> PREP -> ITER -> ROUND -> DONE -> IDLE. DONE lasts exactly 1 cycle.
- Handshake:
  - start is accepted in IDLE or DONE (back-to-back allowed). In DONE, the done pulse still asserts that cycle.
  - start while busy=1 is ignored; no queueing.
- Fixed latency: start sampled at edge T gives done=1 in cycle T+29, for every operand class including specials.
- PREP (1 cycle):
  - Unpack sign = sA^sB.
  - Inputs with exp=0 are flushed to signed zero (FTZ); hidden bit is prepended otherwise.
  - Classify NaN/inf/zero.
  - Compute the 10-bit signed exponent E = eA - eB + BIAS.
- ITER: exactly MAN_W+3 = 26 cycles.
  - Restoring division of 24-bit mantissas; quotient bit q[25] has weight 2^0, so q lies in (0.5, 2).
  - The iteration runs even for specials (its result is discarded), to hold the fixed latency.
- ROUND (1 cycle):
  - If q[25]=1: frac=q[24:2], guard=q[1], sticky=q[0] | (rem!=0).
  - Else: frac=q[23:1], guard=q[0], sticky=(rem!=0), and E=E-1.
  - Round per rnd:
    - RNE: up if guard & (sticky | lsb).
    - toward +inf: up if (guard | sticky) & sign=0.
    - toward -inf: up if (guard | sticky) & sign=1.
    - RTZ: never.
  - Mantissa carry-out renormalises and sets E=E+1.
  - inexact = guard | sticky.
- Overflow (E>=255 after rounding): overflow=1, inexact=1.
  - RNE gives signed inf; RTZ gives signed max finite (0x7F7FFFFF magnitude).
  - Toward +inf: +inf if positive, -max if negative.
  - Toward -inf: -inf if negative, +max if positive.
- Underflow (E<=0 after rounding): result is signed zero (FTZ), with underflow=1 and inexact=1.
- Specials (override arithmetic):
  - NaN operand, 0/0, or inf/inf: result 0x7FC00000, invalid=1.
  - finite nonzero / 0: signed inf, div_by_zero=1.
  - inf / finite: signed inf.
  - finite / inf, or 0 / nonzero: signed zero.
  - No other flags are set for specials.
- Simultaneous events: reset dominates everything. start in the DONE cycle restarts the FSM; busy goes high the next cycle and result is held until the new done.

Test Plan:
- A=0x40C00000 (6.0), B=0x40000000, rnd=00, start at T -> done only at T+29, result=0x40400000, flags=0.
- A=0x3F800000, B=0x40400000 (1/3):
  - rnd=00 -> 0x3EAAAAAB, rnd=01 -> 0x3EAAAAAA, rnd=10 -> 0x3EAAAAAB, rnd=11 -> 0x3EAAAAAA, each with inexact=1.
  - With A=0xBF800000 (-1/3), rnd=10 -> 0xBEAAAAAA.
- Specials:
  - 0x3F800000/0x00000000 -> 0x7F800000, div_by_zero=1.
  - 0/0 -> 0x7FC00000, invalid=1.
  - 0x7F800000/0x7F800000 -> 0x7FC00000, invalid=1.
  - Each still has latency 29.
- Overflow: 0x7F7FFFFF/0x3F000000 -> rnd=00 gives 0x7F800000 and rnd=01 gives 0x7F7FFFFF, both with overflow=1 and inexact=1.
- Underflow: 0x00800000/0x40000000 -> 0x00000000, underflow=1.
- Control:
  - start pulsed again at T+5 is ignored (done only at T+29).
  - start held high in the done cycle gives the second done at T+58.
  - rst driven low at T+10 -> busy=0, result=0, and no done pulse afterwards.

Source files
------------

// File: rtl/fp_div_seq_if.sv
// Request/response bundle for the sequential single-precision divider.
// Latency is set by the divider (fixed, start-to-done); the bundle adds none.
// No backpressure: the master must watch busy/done, starts while busy are dropped.
interface fp_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       rnd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;

    modport master (output start, A, B, rnd, input busy, done, result, flags);
    modport slave  (input start, A, B, rnd, output busy, done, result, flags);
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single divider, radix-2 restoring, FTZ on inputs and outputs.
// Fixed latency: start sampled at edge T gives done during the cycle ending at edge T+29.
// No queueing: start is only taken in IDLE or DONE, ignored while busy.
module fp_div_seq #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic        clk,
    input  logic        rst,
    fp_div_seq_if.slave bus
);
    localparam int QW = MAN_W + 3;
    localparam int CW = $clog2(QW + 1);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic [WIDTH-1:0] INF_MAG = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [WIDTH-1:0] MAX_MAG = {1'b0, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    localparam logic [WIDTH-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0]        a_q, b_q;
    logic [1:0]              rnd_q;
    logic                    sign_q;
    logic signed [EW-1:0]    exp_q;
    logic [MAN_W:0]          div_q;
    logic [MAN_W+1:0]        rem_q;
    logic [QW-1:0]           quo_q;
    logic [CW-1:0]           cnt_q;
    logic                    spec_q;
    logic [WIDTH-1:0]        spec_res_q, result_q;
    logic [4:0]              spec_flg_q, flags_q;
    logic                    busy, done, start_acc;

    // Operand unpack (combinational view of the captured operands, used in PREP)
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        fa, fb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
    logic [MAN_W:0]          ma, mb;
    logic signed [EW-1:0]    e_prep;
    logic                    spec_d;
    logic [WIDTH-1:0]        spec_res_d;
    logic [4:0]              spec_flg_d;

    assign ea     = a_q[WIDTH-2 -: EXP_W];
    assign eb     = b_q[WIDTH-2 -: EXP_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign sgn    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign ma     = a_zero ? '0 : {1'b1, fa};
    assign mb     = b_zero ? '0 : {1'b1, fb};
    assign e_prep = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;

    assign start_acc = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Special-operand classification; the arithmetic result is discarded when spec_d is set
    always_comb begin
        spec_d     = 1'b1;
        spec_res_d = '0;
        spec_flg_d = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res_d = QNAN;
            spec_flg_d = 5'b10000;
        end else if (a_inf) begin
            spec_res_d = {sgn, INF_MAG[WIDTH-2:0]};
        end else if (b_zero) begin
            spec_res_d = {sgn, INF_MAG[WIDTH-2:0]};
            spec_flg_d = 5'b01000;
        end else if (b_inf || a_zero) begin
            spec_res_d = {sgn, {(WIDTH-1){1'b0}}};
        end else begin
            spec_d     = 1'b0;
        end
    end

    // One restoring step: subtract divisor when it fits, then shift the remainder
    logic             q_bit;
    logic [MAN_W+1:0] rem_sub, rem_nxt;
    assign q_bit   = (rem_q >= {1'b0, div_q});
    assign rem_sub = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;
    assign rem_nxt = {rem_sub[MAN_W:0], 1'b0};

    // Normalise, round, and resolve overflow/underflow/specials into the final result
    logic [MAN_W-1:0]     frac, frac_fin;
    logic                 guard, sticky, up, to_inf;
    logic signed [EW-1:0] e_adj, e_fin;
    logic [MAN_W+1:0]     mant_r;
    logic [WIDTH-1:0]     res_d;
    logic [4:0]           flg_d;
    always_comb begin
        if (quo_q[QW-1]) begin
            frac   = quo_q[QW-2:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != '0);
            e_adj  = exp_q;
        end else begin
            frac   = quo_q[QW-3:1];
            guard  = quo_q[0];
            sticky = (rem_q != '0);
            e_adj  = exp_q - E_ONE;
        end
        case (rnd_q)
            2'b00:   up = guard & (sticky | frac[0]);
            2'b10:   up = (guard | sticky) & ~sign_q;
            2'b11:   up = (guard | sticky) & sign_q;
            default: up = 1'b0;
        endcase
        mant_r = {1'b0, 1'b1, frac} + {{(MAN_W+1){1'b0}}, up};
        if (mant_r[MAN_W+1]) begin
            e_fin    = e_adj + E_ONE;
            frac_fin = mant_r[MAN_W:1];
        end else begin
            e_fin    = e_adj;
            frac_fin = mant_r[MAN_W-1:0];
        end
        to_inf = (rnd_q == 2'b00) || ((rnd_q == 2'b10) && !sign_q) || ((rnd_q == 2'b11) && sign_q);
        if (spec_q) begin
            res_d = spec_res_q;
            flg_d = spec_flg_q;
        end else if (e_fin >= E_MAX) begin
            res_d = {sign_q, to_inf ? INF_MAG[WIDTH-2:0] : MAX_MAG[WIDTH-2:0]};
            flg_d = 5'b00101;
        end else if (e_fin <= E_ZERO) begin
            res_d = {sign_q, {(WIDTH-1){1'b0}}};
            flg_d = 5'b00011;
        end else begin
            res_d = {sign_q, e_fin[EXP_W-1:0], frac_fin};
            flg_d = {4'b0000, guard | sticky};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state: fixed PREP(1) + ITER(QW) + ROUND(1) + DONE(1) sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_acc) state_d = S_PREP;
            S_PREP:  state_d = S_ITER;
            S_ITER:  if (cnt_q == CW'(QW - 1)) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = start_acc ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        busy = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_ROUND);
        done = (state_q == S_DONE);
    end

    // Datapath: operand capture, unpack, iteration and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;  b_q <= '0;  rnd_q <= '0;  sign_q <= 1'b0;  exp_q <= '0;
            div_q <= '0;  rem_q <= '0;  quo_q <= '0;  cnt_q <= '0;
            spec_q <= 1'b0;  spec_res_q <= '0;  spec_flg_q <= '0;
            result_q <= '0;  flags_q <= '0;
        end else begin
            if (start_acc) begin
                a_q   <= bus.A;
                b_q   <= bus.B;
                rnd_q <= bus.rnd;
            end
            case (state_q)
                S_PREP: begin
                    sign_q     <= sgn;
                    exp_q      <= e_prep;
                    div_q      <= mb;
                    rem_q      <= {1'b0, ma};
                    quo_q      <= '0;
                    cnt_q      <= '0;
                    spec_q     <= spec_d;
                    spec_res_q <= spec_res_d;
                    spec_flg_q <= spec_flg_d;
                end
                S_ITER: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[QW-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                end
                S_ROUND: begin
                    result_q <= res_d;
                    flags_q  <= flg_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;
endmodule
